inst_fetch_unit: RTL and testbench

Fetch stage that owns the fetch PC, drives the dual-bank program ROM address and bank-select lines, and captures the two halfwords the ROM returns each cycle into a small instruction queue. It sits directly upstream of decode: it presents up to two queued Thumb instructions per cycle and retires however many decode takes. It also handles branch redirects, which flush the queue and restart fetch at the target.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/inst_fetch_unit_if.sv | 33 +++
 rtl/inst_queue.sv | 73 +++++++
 rtl/inst_fetch_unit.sv | 83 ++++++++
 tb/tb_inst_fetch_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and ROM bank-select encodings for the instruction fetch unit.
// Both inst_queue and inst_fetch_unit import this package.
package fetch_pkg;

   typedef logic [15:0] inst_t;
   typedef logic [14:0] hw_pc_t;

   localparam logic [1:0] SEL0_DATA0 = 2'd0;
   localparam logic [1:0] SEL0_IR1   = 2'd1;
   localparam logic [1:0] SEL0_DATA1 = 2'd2;
   localparam logic       SEL1_DATA0 = 1'b0;
   localparam logic       SEL1_DATA1 = 1'b1;

   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundles the fetch unit's ROM-side and decode-side signals.
// The master modport is the fetch unit; the slave modport is the ROM/decode environment.
interface inst_fetch_unit_if;
   import fetch_pkg::*;

   logic        redirect_valid;
   logic [15:0] redirect_addr;
   logic [13:0] Rom_addr_out;
   logic        pc_1;
   logic        sel_mem_1;
   logic [1:0]  sel_mem_0;
   inst_t       IR_0_in;
   inst_t       IR_1_in;
   logic        inst0_valid;
   logic        inst1_valid;
   inst_t       inst0;
   inst_t       inst1;
   logic [15:0] inst0_pc;
   logic [1:0]  take;

   modport master (
      input  redirect_valid, redirect_addr, IR_0_in, IR_1_in, take,
      output Rom_addr_out, pc_1, sel_mem_1, sel_mem_0,
             inst0_valid, inst1_valid, inst0, inst1, inst0_pc
   );

   modport slave (
      output redirect_valid, redirect_addr, IR_0_in, IR_1_in, take,
      input  Rom_addr_out, pc_1, sel_mem_1, sel_mem_0,
             inst0_valid, inst1_valid, inst0, inst1, inst0_pc
   );

endinterface

// File: rtl/inst_queue.sv
// Circular buffer of halfword instructions: writes two entries at once, reads 0-2.
// Flush empties it and has priority over both read and write.
module inst_queue
   import fetch_pkg::*;
#(
   parameter  int QDEPTH = 4,
   localparam int PW     = $clog2(QDEPTH),
   localparam int CW     = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          wr_en,
   input  inst_t         wr_data0,
   input  inst_t         wr_data1,
   input  logic [1:0]    rd_num,
   output inst_t         rd_data0,
   output inst_t         rd_data1,
   output logic [CW-1:0] count
);

   inst_t         mem_q [QDEPTH];
   inst_t         mem_d [QDEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_next;
   logic [PW-1:0] rd_ptr_next;

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      wr_ptr_next = wr_ptr_q + PW'(1);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) begin
            mem_d[wr_ptr_q]    = wr_data0;
            mem_d[wr_ptr_next] = wr_data1;
            wr_ptr_d           = wr_ptr_q + PW'(2);
         end
         rd_ptr_d = rd_ptr_q + PW'(rd_num);
         count_d  = count_q - CW'(rd_num) + (wr_en ? CW'(2) : CW'(0));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QDEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Head outputs read straight from registered storage, so nothing from take reaches them.
   assign rd_ptr_next = rd_ptr_q + PW'(1);
   assign rd_data0    = mem_q[rd_ptr_q];
   assign rd_data1    = mem_q[rd_ptr_next];
   assign count       = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC, drives the dual-bank ROM, queues returned halfwords
// and presents up to two of them to decode each cycle. Redirects flush and refetch.
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter int          QDEPTH   = 4,
   parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
   input logic                clk,
   input logic                rst_n,
   inst_fetch_unit_if.master  bus
);

   localparam int CW = $clog2(QDEPTH) + 1;

   hw_pc_t        fpc_q, fpc_d;
   logic [15:0]   head_pc_q, head_pc_d;
   logic [CW-1:0] count;
   logic [1:0]    eff;
   logic [CW:0]   room;
   logic          enq;
   logic          unused_redirect_lsb;

   // Over-take is clamped to what is actually queued.
   always_comb begin
      eff = bus.take;
      if (CW'(bus.take) > count) begin
         eff = count[1:0];
      end
      room = (CW+1)'(QDEPTH) - (CW+1)'(count) + (CW+1)'(eff);
      enq  = !bus.redirect_valid && (room >= (CW+1)'(2));
   end

   always_comb begin
      fpc_d     = fpc_q;
      head_pc_d = head_pc_q;
      if (bus.redirect_valid) begin
         fpc_d     = bus.redirect_addr[15:1];
         head_pc_d = {bus.redirect_addr[15:1], 1'b0};
      end else begin
         if (enq) begin
            fpc_d = fpc_q + 15'd2;
         end
         head_pc_d = head_pc_q + 16'({eff, 1'b0});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpc_q     <= RESET_PC[15:1];
         head_pc_q <= {RESET_PC[15:1], 1'b0};
      end else begin
         fpc_q     <= fpc_d;
         head_pc_q <= head_pc_d;
      end
   end

   inst_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (bus.redirect_valid),
      .wr_en    (enq),
      .wr_data0 (bus.IR_0_in),
      .wr_data1 (bus.IR_1_in),
      .rd_num   (eff),
      .rd_data0 (bus.inst0),
      .rd_data1 (bus.inst1),
      .count    (count)
   );

   // Odd fetch PC: IR_0 comes from bank 1 and IR_1 from bank 0 at the next pair index.
   assign bus.Rom_addr_out = fpc_q[14:1];
   assign bus.pc_1         = fpc_q[0];
   assign bus.sel_mem_0    = fpc_q[0] ? SEL0_DATA1 : SEL0_DATA0;
   assign bus.sel_mem_1    = fpc_q[0] ? SEL1_DATA0 : SEL1_DATA1;

   assign bus.inst0_valid  = (count != '0);
   assign bus.inst1_valid  = (count >= CW'(2));
   assign bus.inst0_pc     = head_pc_q;

   assign unused_redirect_lsb = bus.redirect_addr[0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus random take/redirect
// traffic, all checked against a queue-based reference model of the fetch stage.
module tb_inst_fetch_unit;
   import fetch_pkg::*;

   localparam int          QDEPTH   = 4;
   localparam logic [15:0] RESET_PC = 16'h0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   assertCount = 0;
   int   failCount = 0;

   always #5 clk = ~clk;

   inst_fetch_unit_if bus_if ();

   inst_fetch_unit #(.QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.master)
   );

   function automatic inst_t romWord(input hw_pc_t k);
      return 16'h1000 + {1'b0, k};
   endfunction

   // Two-bank ROM: bank 0 holds even halfwords, bank 1 odd; bank 0 reads the next pair when pc_1 is set.
   logic [13:0] bank0_addr;
   inst_t       bank0_word, bank1_word;
   always_comb begin
      bank0_addr = bus_if.Rom_addr_out + 14'(bus_if.pc_1);
      bank0_word = romWord({bank0_addr, 1'b0});
      bank1_word = romWord({bus_if.Rom_addr_out, 1'b1});
      bus_if.IR_0_in = 16'hDEAD;
      case (bus_if.sel_mem_0)
         2'd0:    bus_if.IR_0_in = bank0_word;
         2'd2:    bus_if.IR_0_in = bank1_word;
         default: bus_if.IR_0_in = 16'hDEAD;
      endcase
      bus_if.IR_1_in = bus_if.sel_mem_1 ? bank1_word : bank0_word;
   end

   hw_pc_t mfpc;
   hw_pc_t mq[$];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      mfpc = RESET_PC[15:1];
   endtask

   task automatic modelStep(input int tk, input bit rd, input logic [15:0] ra);
      int n;
      int eff;
      if (rd) begin
         mq.delete();
         mfpc = ra[15:1];
      end else begin
         n   = mq.size();
         eff = (tk > n) ? n : tk;
         repeat (eff) void'(mq.pop_front());
         if (QDEPTH - mq.size() >= 2) begin
            mq.push_back(mfpc);
            mq.push_back(mfpc + 15'd1);
            mfpc = mfpc + 15'd2;
         end
      end
   endtask

   task automatic compareAll(input string ph);
      checkOutput({ph, "_rom_addr"}, 32'(bus_if.Rom_addr_out), 32'(mfpc[14:1]));
      checkOutput({ph, "_pc_1"}, 32'(bus_if.pc_1), 32'(mfpc[0]));
      checkOutput({ph, "_sel0"}, 32'(bus_if.sel_mem_0), mfpc[0] ? 32'd2 : 32'd0);
      checkOutput({ph, "_sel1"}, 32'(bus_if.sel_mem_1), mfpc[0] ? 32'd0 : 32'd1);
      checkOutput({ph, "_valid0"}, 32'(bus_if.inst0_valid), 32'(mq.size() >= 1));
      checkOutput({ph, "_valid1"}, 32'(bus_if.inst1_valid), 32'(mq.size() >= 2));
      if (mq.size() >= 1) begin
         checkOutput({ph, "_inst0"}, 32'(bus_if.inst0), 32'(romWord(mq[0])));
         checkOutput({ph, "_inst0_pc"}, 32'(bus_if.inst0_pc), 32'({mq[0], 1'b0}));
      end
      if (mq.size() >= 2) begin
         checkOutput({ph, "_inst1"}, 32'(bus_if.inst1), 32'(romWord(mq[1])));
      end
   endtask

   // Called at a falling edge: drive inputs, let one rising edge pass, then check.
   task automatic applyStimulus(input int tk, input bit rd, input logic [15:0] ra, input string ph);
      assert (rd || tk <= mq.size())
         else $error("[TB] take %0d exceeds queued count %0d", tk, mq.size());
      bus_if.take           = 2'(tk);
      bus_if.redirect_valid = rd;
      bus_if.redirect_addr  = ra;
      @(posedge clk);
      modelStep(tk, rd, ra);
      @(negedge clk);
      compareAll(ph);
   endtask

   initial begin
      int lim;
      int tk;
      bit rd;
      bus_if.take           = 2'd0;
      bus_if.redirect_valid = 1'b0;
      bus_if.redirect_addr  = 16'h0000;
      rst_n = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      compareAll("reset");
      rst_n = 1'b1;

      applyStimulus(0, 1'b0, 16'h0, "start1");
      checkOutput("start_rom_addr", 32'(bus_if.Rom_addr_out), 32'd1);
      checkOutput("start_inst0", 32'(bus_if.inst0), 32'h1000);
      checkOutput("start_inst1", 32'(bus_if.inst1), 32'h1001);
      checkOutput("start_inst0_pc", 32'(bus_if.inst0_pc), 32'h0);
      applyStimulus(0, 1'b0, 16'h0, "start2");
      applyStimulus(0, 1'b0, 16'h0, "hold");
      checkOutput("hold_rom_addr", 32'(bus_if.Rom_addr_out), 32'd2);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(2, 1'b0, 16'h0, "take2");
         checkOutput("take2_inst0_pc", 32'(bus_if.inst0_pc), 32'(16'(4 * (i + 1))));
      end

      applyStimulus(0, 1'b1, 16'h0006, "redir6");
      checkOutput("redir6_rom_addr", 32'(bus_if.Rom_addr_out), 32'd1);
      checkOutput("redir6_pc_1", 32'(bus_if.pc_1), 32'd1);
      checkOutput("redir6_sel0", 32'(bus_if.sel_mem_0), 32'd2);
      checkOutput("redir6_sel1", 32'(bus_if.sel_mem_1), 32'd0);
      applyStimulus(0, 1'b0, 16'h0, "redir6_tgt");
      checkOutput("redir6_inst0", 32'(bus_if.inst0), 32'h1003);
      checkOutput("redir6_inst1", 32'(bus_if.inst1), 32'h1004);
      checkOutput("redir6_inst0_pc", 32'(bus_if.inst0_pc), 32'h0006);

      applyStimulus(0, 1'b0, 16'h0, "fill");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1'b0, 16'h0, "take1");
      end

      applyStimulus(0, 1'b0, 16'h0, "refill");
      applyStimulus(0, 1'b0, 16'h0, "refill");
      applyStimulus(2, 1'b1, 16'h0040, "redir_full");
      checkOutput("redir_full_valid0", 32'(bus_if.inst0_valid), 32'd0);
      checkOutput("redir_full_valid1", 32'(bus_if.inst1_valid), 32'd0);
      applyStimulus(0, 1'b0, 16'h0, "redir_full_tgt");
      checkOutput("redir_full_inst0", 32'(bus_if.inst0), 32'h1020);

      applyStimulus(0, 1'b1, 16'hFFFC, "wrap_redir");
      applyStimulus(0, 1'b0, 16'h0, "wrap_fill");
      checkOutput("wrap_pc_before", 32'(bus_if.inst0_pc), 32'hFFFC);
      applyStimulus(0, 1'b0, 16'h0, "wrap_fill");
      applyStimulus(2, 1'b0, 16'h0, "wrap");
      checkOutput("wrap_inst0_pc", 32'(bus_if.inst0_pc), 32'h0000);
      checkOutput("wrap_inst0", 32'(bus_if.inst0), 32'h1000);

      for (int i = 0; i < 400; i++) begin
         lim = (mq.size() > 2) ? 2 : mq.size();
         tk  = $urandom_range(lim, 0);
         rd  = ($urandom_range(15, 0) == 0);
         applyStimulus(tk, rd, 16'($urandom), "rand");
      end

      applyStimulus(0, 1'b0, 16'h0, "pre_rst");
      applyStimulus(0, 1'b0, 16'h0, "pre_rst");
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid0", 32'(bus_if.inst0_valid), 32'd0);
      checkOutput("async_rst_valid1", 32'(bus_if.inst1_valid), 32'd0);
      checkOutput("async_rst_rom_addr", 32'(bus_if.Rom_addr_out), 32'(RESET_PC[14:2]));
      modelReset();
      @(negedge clk);
      compareAll("in_rst");
      rst_n = 1'b1;
      applyStimulus(0, 1'b0, 16'h0, "post_rst");
      checkOutput("post_rst_inst0", 32'(bus_if.inst0), 32'h1000);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(i % 3, 1'b0, 16'h0, "post_rst_run");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
